// File: rtl/display_pkg.sv
// Shared page encodings for the display page multiplexer.
package display_pkg;

  localparam int PAGE_W = 2;

  typedef enum logic [PAGE_W-1:0] {
    PG_XY  = 2'd0,
    PG_SAD = 2'd1,
    PG_PC  = 2'd2,
    PG_WB  = 2'd3
  } page_e;

  // Pages rotate in order and wrap from PG_WB back to PG_XY.
  function automatic page_e next_page(input page_e p);
    return page_e'(p + 2'd1);
  endfunction

endpackage

// File: rtl/display_page_mux_if.sv
// Datapath-side values, page controls and display-side values of the page mux.
interface display_page_mux_if;
  import display_pkg::*;

  logic [31:0]       xCoord;
  logic [31:0]       yCoord;
  logic [31:0]       sad;
  logic [31:0]       PCResult;
  logic [31:0]       WritebackOutput;
  logic              Step;
  logic              Hold;
  logic [15:0]       LeftValue;
  logic [15:0]       RightValue;
  logic [PAGE_W-1:0] Page;

  modport master (
    output xCoord, yCoord, sad, PCResult, WritebackOutput, Step, Hold,
    input  LeftValue, RightValue, Page
  );

  modport slave (
    input  xCoord, yCoord, sad, PCResult, WritebackOutput, Step, Hold,
    output LeftValue, RightValue, Page
  );

endinterface

// File: rtl/display_page_mux_tick_prescaler.sv
// Free-running 0..TICK_DIV-1 counter producing a one-cycle tick at the top count.
// Freezes while en_i is low; restart_i forces the count back to zero.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick_o  = en_i & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_page_mux.sv
// Rotates the two four-digit display values through XY, SAD, PC and writeback pages.
// Pages advance on a prescaled tick (unless held) or on a manual Step rising edge.
module display_page_mux #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic              Clk,
  input  logic              Reset,
  display_page_mux_if.slave bus
);
  import display_pkg::*;

  page_e       page_q;
  page_e       page_d;
  logic        step_q;
  logic        step_edge;
  logic        tick;
  logic [15:0] left_q;
  logic [15:0] left_d;
  logic [15:0] right_q;
  logic [15:0] right_d;
  logic        unused_hi;

  // Coordinates only ever show their low halves.
  assign unused_hi = ^{bus.xCoord[31:16], bus.yCoord[31:16]};

  assign step_edge = bus.Step & ~step_q;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .en_i      (~bus.Hold),
    .restart_i (step_edge),
    .tick_o    (tick)
  );

  // A tick and a Step edge in the same cycle still advance by one page.
  always_comb begin
    page_d = page_q;
    if (tick || step_edge) begin
      page_d = next_page(page_q);
    end
  end

  always_comb begin
    left_d  = bus.sad[31:16];
    right_d = bus.sad[15:0];
    case (page_q)
      PG_XY: begin
        left_d  = bus.yCoord[15:0];
        right_d = bus.xCoord[15:0];
      end
      PG_SAD: begin
        left_d  = bus.sad[31:16];
        right_d = bus.sad[15:0];
      end
      PG_PC: begin
        left_d  = bus.PCResult[31:16];
        right_d = bus.PCResult[15:0];
      end
      PG_WB: begin
        left_d  = bus.WritebackOutput[31:16];
        right_d = bus.WritebackOutput[15:0];
      end
      default: begin
        left_d  = bus.yCoord[15:0];
        right_d = bus.xCoord[15:0];
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      page_q  <= PG_XY;
      step_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      page_q  <= page_d;
      step_q  <= bus.Step;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign bus.Page       = page_q;
  assign bus.LeftValue  = left_q;
  assign bus.RightValue = right_q;

endmodule

// File: tb/tb_display_page_mux.sv
// Directed and random checks of display_page_mux against a cycle-level reference model.
module tb_display_page_mux;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Reference model state: page index, prescaler count, last Step, shown values.
  int          m_page;
  int          m_cnt;
  bit          m_prev;
  logic [15:0] m_left;
  logic [15:0] m_right;

  always #5 clk = ~clk;

  display_page_mux_if u_if();

  display_page_mux #(
    .TICK_DIV (TD)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (u_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] page_source(input int pg);
    case (pg)
      0:       return {u_if.yCoord[15:0], u_if.xCoord[15:0]};
      1:       return u_if.sad;
      2:       return u_if.PCResult;
      default: return u_if.WritebackOutput;
    endcase
  endfunction

  task automatic model_update();
    bit step_edge;
    bit tick;
    logic [31:0] src;
    if (rst) begin
      m_page  = 0;
      m_cnt   = 0;
      m_prev  = 0;
      m_left  = 16'h0;
      m_right = 16'h0;
    end else begin
      src       = page_source(m_page);
      m_left    = src[31:16];
      m_right   = src[15:0];
      step_edge = u_if.Step && !m_prev;
      tick      = !u_if.Hold && (m_cnt == TD - 1);
      if (step_edge || tick) m_page = (m_page + 1) % 4;
      if (step_edge)         m_cnt = 0;
      else if (!u_if.Hold)   m_cnt = (m_cnt + 1) % TD;
      m_prev = u_if.Step;
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      #1;
      check("model_page",  {30'd0, u_if.Page}, m_page);
      check("model_left",  {16'd0, u_if.LeftValue}, {16'd0, m_left});
      check("model_right", {16'd0, u_if.RightValue}, {16'd0, m_right});
    end
  endtask

  initial begin
    rst                  = 1'b1;
    u_if.xCoord          = 32'h0000_0012;
    u_if.yCoord          = 32'h0000_0034;
    u_if.sad             = 32'h0;
    u_if.PCResult        = 32'h1111_2222;
    u_if.WritebackOutput = 32'h3333_4444;
    u_if.Step            = 1'b0;
    u_if.Hold            = 1'b0;

    // Reset held for two cycles
    cyc(2);
    check("rst_page",  {30'd0, u_if.Page}, 32'd0);
    check("rst_left",  {16'd0, u_if.LeftValue}, 32'h0);
    check("rst_right", {16'd0, u_if.RightValue}, 32'h0);
    rst = 1'b0;
    cyc(1);
    check("rel_left",  {16'd0, u_if.LeftValue}, 32'h0034);
    check("rel_right", {16'd0, u_if.RightValue}, 32'h0012);

    // Auto-advance every TD cycles
    cyc(2);
    check("auto_p0", {30'd0, u_if.Page}, 32'd0);
    cyc(1);
    check("auto_p1", {30'd0, u_if.Page}, 32'd1);
    u_if.sad = 32'hABCD_1234;
    cyc(1);
    check("sad_left",  {16'd0, u_if.LeftValue}, 32'hABCD);
    check("sad_right", {16'd0, u_if.RightValue}, 32'h1234);
    cyc(3);
    check("auto_p2", {30'd0, u_if.Page}, 32'd2);
    cyc(4);
    check("auto_p3", {30'd0, u_if.Page}, 32'd3);
    cyc(4);
    check("auto_wrap", {30'd0, u_if.Page}, 32'd0);

    // Hold on page 2 with prescaler at 2
    cyc(10);
    u_if.Hold = 1'b1;
    cyc(20);
    check("hold_p2", {30'd0, u_if.Page}, 32'd2);
    u_if.Hold = 1'b0;
    cyc(1);
    check("hold_rel_p2", {30'd0, u_if.Page}, 32'd2);
    cyc(1);
    check("hold_rel_p3", {30'd0, u_if.Page}, 32'd3);

    // Step held high with Hold=1: single advance
    u_if.Hold = 1'b1;
    u_if.Step = 1'b1;
    cyc(10);
    check("step_once", {30'd0, u_if.Page}, 32'd0);
    u_if.Step = 1'b0;
    u_if.Hold = 1'b0;
    cyc(3);
    check("step_pre_tick", {30'd0, u_if.Page}, 32'd0);
    cyc(1);
    check("step_tick", {30'd0, u_if.Page}, 32'd1);

    // Step edge coinciding with tick on page 3
    cyc(11);
    check("coll_pre", {30'd0, u_if.Page}, 32'd3);
    u_if.Step = 1'b1;
    cyc(1);
    check("coll_page", {30'd0, u_if.Page}, 32'd0);
    u_if.Step = 1'b0;
    cyc(3);
    check("coll_restart", {30'd0, u_if.Page}, 32'd0);
    cyc(1);
    check("coll_tick", {30'd0, u_if.Page}, 32'd1);

    // Reset pulse at prescaler=2 on page 2
    cyc(6);
    check("mrst_pre", {30'd0, u_if.Page}, 32'd2);
    rst = 1'b1;
    cyc(1);
    check("mrst_page", {30'd0, u_if.Page}, 32'd0);
    rst = 1'b0;
    cyc(3);
    check("mrst_count", {30'd0, u_if.Page}, 32'd0);
    cyc(1);
    check("mrst_tick", {30'd0, u_if.Page}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst                  = ($urandom_range(0, 79) == 0);
      u_if.xCoord          = $urandom;
      u_if.yCoord          = $urandom;
      u_if.sad             = $urandom;
      u_if.PCResult        = $urandom;
      u_if.WritebackOutput = $urandom;
      if ($urandom_range(0, 5) == 0) u_if.Step = ~u_if.Step;
      if ($urandom_range(0, 9) == 0) u_if.Hold = ~u_if.Hold;
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_page_mux.md
DISPLAY_PAGE_MUX -- requirements
Module: display_page_mux

Interface
REQ-001 SHALL have parameter TICK_DIV, 100000000, clock cycles per auto-advance tick (1 s at 100 MHz); legal range 2..2^32-1.
REQ-002 SHALL have port Clk input 1 system clock; all logic on rising edge; one clock domain.
REQ-003 SHALL have port Reset input 1 reset; synchronous, active-high.
REQ-004 SHALL have port xCoord input 32 best-match X from datapath.
REQ-005 SHALL have port yCoord input 32 best-match Y from datapath.
REQ-006 SHALL have port sad input 32 best SAD value from datapath.
REQ-007 SHALL have port PCResult input 32 current PC from datapath.
REQ-008 SHALL have port WritebackOutput input 32 writeback bus from datapath.
REQ-009 SHALL have port Step input 1 synchronous, debounced manual page-advance request (level).
REQ-010 SHALL have port Hold input 1 level; 1 freezes auto-advance.
REQ-011 SHALL have port LeftValue output 16 left four-digit value, feeds display driver.
REQ-012 SHALL have port RightValue output 16 right four-digit value, feeds display driver.
REQ-013 SHALL have port Page output 2 current page index.

Function
REQ-014 SHALL implement page FSM with states PG_XY=0, PG_SAD=1, PG_PC=2, PG_WB=3, advancing 0->1->2->3->0 (wrap at 3).
REQ-015 SHALL select per page: PG_XY Left=yCoord[15:0], Right=xCoord[15:0]; PG_SAD/PG_PC/PG_WB Left=source[31:16], Right=source[15:0].
REQ-016 SHALL register LeftValue/RightValue: an input change appears on outputs exactly 1 cycle later; a page change appears on outputs 1 cycle after Page updates.
REQ-017 SHALL run a prescaler counter 0..TICK_DIV-1; tick pulses for one cycle when counter equals TICK_DIV-1, and the counter then wraps to 0.
REQ-018 SHALL advance the page on tick only when Hold=0; while Hold=1 the prescaler holds its value and no tick is generated.
REQ-019 SHALL detect Step rising edge (Step=1, previous-cycle Step=0) and advance the page on the next edge, independent of Hold.
REQ-020 SHALL restart the prescaler at 0 on each Step edge.
REQ-021 SHALL advance exactly one page when a tick and a Step edge fall in the same cycle; prescaler to 0.
REQ-022 SHALL treat Step held high as a single edge; no repeat advance.
REQ-023 SHALL size the prescaler with $clog2(TICK_DIV) bits; no overflow for any legal TICK_DIV.

Reset
REQ-024 SHALL on Reset=1 set Page=PG_XY, prescaler=0, Step history=0, LeftValue=0, RightValue=0 at the next edge.
REQ-025 SHALL give Reset priority over tick, Step and Hold; asserted mid-count, the next non-reset cycle starts counting from 0.
REQ-026 SHALL after reset release load outputs from PG_XY sources on the first non-reset edge.

Structure
REQ-027 SHALL place page encodings PG_XY..PG_WB and page width (2) in shared package display_pkg; TICK_DIV stays a module parameter.
REQ-028 SHALL contain one sub-module, tick_prescaler (counter, Hold enable, restart input, tick output); the rest flat.
REQ-029 SHALL sit between top_level datapath outputs and Two4DigitDisplay inputs in the board top, replacing direct xCoord/yCoord wiring.

Verification (bench uses TICK_DIV=4)
REQ-030 SHALL verify reset: Reset=1 for 2 cycles, xCoord=0x00000012, yCoord=0x00000034 -> Page=0, then Left=0x0034, Right=0x0012 one cycle after release.
REQ-031 SHALL verify auto-advance: Hold=0, Step=0 -> Page steps 0,1,2,3,0 every 4 cycles; on page 1 with sad=0xABCD1234 -> Left=0xABCD, Right=0x1234.
REQ-032 SHALL verify Hold: Hold=1 for 20 cycles on page 2 -> Page stays 2; Hold=0 -> advances to 3 after the remaining prescaler count.
REQ-033 SHALL verify Step: Step high 10 cycles with Hold=1 -> exactly one advance; next auto tick 4 cycles after the edge once Hold=0.
REQ-034 SHALL verify collision: Step edge in the same cycle as tick on page 3 -> Page=0, not 1; prescaler restarts.
REQ-035 SHALL verify mid-count reset: Reset pulse at prescaler=2 on page 2 -> Page=0, next tick 4 cycles after release.
